// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, column constants and code helpers for the
// 4x4 keypad scan controller.
package keypad_pkg;

  localparam int unsigned RowW  = 4;
  localparam int unsigned ColW  = 4;
  localparam int unsigned CodeW = 4;

  // Scan FSM state encoding
  typedef logic [1:0] scan_state_t;

  localparam scan_state_t StScan     = 2'd0;
  localparam scan_state_t StDebounce = 2'd1;
  localparam scan_state_t StHeld     = 2'd2;

  // One-hot column strobes
  localparam logic [ColW-1:0] Col0     = 4'b0001;
  localparam logic [ColW-1:0] Col1     = 4'b0010;
  localparam logic [ColW-1:0] Col2     = 4'b0100;
  localparam logic [ColW-1:0] Col3     = 4'b1000;
  localparam logic [ColW-1:0] ColReset = Col0;

  // Key code is row_index*4 + col_index
  function automatic logic [CodeW-1:0] encode_code(input logic [1:0] row_idx,
                                                   input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  // Lowest set row bit wins, so ghosted patterns resolve to the lowest row
  function automatic logic [1:0] lowest_row(input logic [RowW-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = RowW - 1; i >= 0; i--) begin
      if (r[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  // Index of the currently driven column
  function automatic logic [1:0] col_index(input logic [ColW-1:0] c);
    logic [1:0] idx;
    case (c)
      Col1:    idx = 2'd1;
      Col2:    idx = 2'd2;
      Col3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Rotate 0001 -> 0010 -> 0100 -> 1000 -> 0001
  function automatic logic [ColW-1:0] next_col(input logic [ColW-1:0] c);
    return {c[ColW-2:0], c[ColW-1]};
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchronizer bringing the raw keypad row lines into
// the Clk domain.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [RowW-1:0] row,
  output logic [RowW-1:0] row_s
);

  logic [RowW-1:0] meta_q;
  logic [RowW-1:0] sync_q;

  // Two-stage capture of the asynchronous row lines
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= row;
      sync_q <= meta_q;
    end
  end

  assign row_s = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scan, press/release debounce and valid/ack hand-off
// of 4-bit key codes for a 4x4 matrix keypad.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 7,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [RowW-1:0]  row,
  input  logic             key_ack,
  output logic [ColW-1:0]  col,
  output logic [CodeW-1:0] code,
  output logic             key_valid,
  output logic             key_held,
  output logic             overrun
);

  localparam int unsigned       DwellW    = $clog2(SCAN_DIV);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam int unsigned       CntW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam bit                RepeatEn  = 1'b1;
  localparam int unsigned       RptW      = $clog2(REPEAT_SCANS + 1);
  localparam logic [RptW-1:0]   RptDone   = RptW'(REPEAT_SCANS);
`else
  localparam bit                RepeatEn  = 1'b0;
`endif

  // Stop elaboration on parameter values that cannot scan correctly
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || (RepeatEn && REPEAT_SCANS < 1)) begin : g_bad_param
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  logic [RowW-1:0]   row_s;
  logic              sample;
  logic              row_hit;
  logic [CodeW-1:0]  sample_code;
  logic              accept;

  scan_state_t       state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [CodeW-1:0]  cand_q, cand_d;
  logic [CntW-1:0]   match_q, match_d, match_inc;
  logic [CntW-1:0]   rel_q, rel_d, rel_inc;
  logic              held_q, held_d;
  logic              valid_q, valid_d;
  logic [CodeW-1:0]  code_q, code_d;
  logic              ovr_q, ovr_d;
`ifdef KEYPAD_REPEAT_EN
  logic [RptW-1:0]   rpt_q, rpt_d, rpt_inc;
`endif

  keypad_row_sync u_row_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .row     (row),
    .row_s   (row_s)
  );

  // Row lines are only looked at on the last dwell cycle of each column
  assign sample      = (dwell_q == DwellLast);
  assign dwell_d     = sample ? '0 : dwell_q + 1'b1;
  assign row_hit     = |row_s;
  assign sample_code = encode_code(lowest_row(row_s), col_index(col_q));
  assign match_inc   = match_q + 1'b1;
  assign rel_inc     = rel_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
  assign rpt_inc     = rpt_q + 1'b1;
`endif

  // Scan/debounce/held sequencing, evaluated once per sample event
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    match_d = match_q;
    rel_d   = rel_q;
    held_d  = held_q;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (sample) begin
      case (state_q)
        StScan: begin
          if (!row_hit) begin
            col_d = next_col(col_q);
          end else begin
            cand_d  = sample_code;
            match_d = CntOne;
            if (CntDone == CntOne) accept = 1'b1;
            else                   state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (row_hit && (sample_code == cand_q)) begin
            match_d = match_inc;
            if (match_inc == CntDone) accept = 1'b1;
          end else begin
            match_d = '0;
            col_d   = next_col(col_q);
            state_d = StScan;
          end
        end
        StHeld: begin
          if (!row_hit) begin
            rel_d = rel_inc;
`ifdef KEYPAD_REPEAT_EN
            rpt_d = '0;
`endif
            if (rel_inc == CntDone) begin
              rel_d   = '0;
              held_d  = 1'b0;
              col_d   = next_col(col_q);
              state_d = StScan;
            end
          end else begin
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d = rpt_inc;
            if (rpt_inc == RptDone) accept = 1'b1;
`endif
          end
        end
        default: begin
          state_d = StScan;
          col_d   = ColReset;
          match_d = '0;
          rel_d   = '0;
        end
      endcase
    end
    if (accept) begin
      state_d = StHeld;
      held_d  = 1'b1;
      match_d = '0;
      rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_d   = '0;
`endif
    end
  end

  // Consumer hand-off: an accept in the same cycle as key_ack wins and is not an overrun
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (key_ack && valid_q) valid_d = 1'b0;
    if (accept) begin
      if (valid_q && !key_ack) ovr_d = 1'b1;
      valid_d = 1'b1;
      code_d  = cand_d;
    end
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StScan;
      dwell_q <= '0;
      col_q   <= ColReset;
      cand_q  <= '0;
      match_q <= '0;
      rel_q   <= '0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      rel_q   <= rel_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign col       = col_q;
  assign code      = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed vector table for the scan/debounce scenarios,
// hand sequences for async reset, then random rows checked against an
// event-level model of the keypad controller.
module tb_keypad_scan_ctrl;

  localparam int unsigned ScanDiv  = 7;
  localparam int unsigned DebScans = 3;
  localparam int unsigned RepScans = 64;

  localparam int PhScan     = 0;
  localparam int PhDebounce = 1;
  localparam int PhHeld     = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] row;
  logic       key_ack;
  logic [3:0] col;
  logic [3:0] code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  bit use_model = 1'b0;

  // Bundle layout: {col, code, key_valid, key_held, overrun}
  typedef struct {
    logic [3:0]  row;
    logic        ack;
    int          n;
    logic [10:0] exp;
  } vec_t;

  // Reference model state
  logic [3:0] m_pipe [2];
  int         m_cyc;
  int         m_colpos;
  int         m_phase;
  int         m_cand;
  int         m_hits;
  int         m_zeros;
  int         m_since;
  int         m_code;
  bit         m_valid;
  bit         m_held;
  bit         m_ovr;

  always #5 Clk = ~Clk;

  keypad_scan_ctrl #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_SCANS (DebScans),
    .REPEAT_SCANS   (RepScans)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .row       (row),
    .key_ack   (key_ack),
    .col       (col),
    .code      (code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  function automatic int first_row(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pipe[0] = 4'h0;
    m_pipe[1] = 4'h0;
    m_cyc     = 0;
    m_colpos  = 0;
    m_phase   = PhScan;
    m_cand    = 0;
    m_hits    = 0;
    m_zeros   = 0;
    m_since   = 0;
    m_code    = 0;
    m_valid   = 1'b0;
    m_held    = 1'b0;
    m_ovr     = 1'b0;
  endtask

  // One clock edge of the model; r/a are the inputs present at that edge
  task automatic model_edge(input logic [3:0] r, input bit a);
    logic [3:0] rs;
    int         ri;
    bit         smp;
    bit         was_valid;
    bit         acc;
    rs        = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = r;
    smp       = ((m_cyc % ScanDiv) == ScanDiv - 1);
    m_cyc++;
    was_valid = m_valid;
    acc       = 1'b0;
    if (a && m_valid) m_valid = 1'b0;
    if (smp) begin
      ri = first_row(rs);
      if (m_phase == PhScan) begin
        if (ri < 0) begin
          m_colpos = (m_colpos + 1) % 4;
        end else begin
          m_cand = ri * 4 + m_colpos;
          m_hits = 1;
          if (m_hits == DebScans) acc = 1'b1;
          else                    m_phase = PhDebounce;
        end
      end else if (m_phase == PhDebounce) begin
        if (ri >= 0 && (ri * 4 + m_colpos) == m_cand) begin
          m_hits++;
          if (m_hits == DebScans) acc = 1'b1;
        end else begin
          m_colpos = (m_colpos + 1) % 4;
          m_phase  = PhScan;
        end
      end else begin
        if (ri < 0) begin
          m_zeros++;
          m_since = 0;
          if (m_zeros == DebScans) begin
            m_held   = 1'b0;
            m_colpos = (m_colpos + 1) % 4;
            m_phase  = PhScan;
          end
        end else begin
          m_zeros = 0;
`ifdef KEYPAD_REPEAT_EN
          m_since++;
          if (m_since == RepScans) acc = 1'b1;
`endif
        end
      end
    end
    if (acc) begin
      if (was_valid && !a) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_code  = m_cand;
      m_held  = 1'b1;
      m_phase = PhHeld;
      m_zeros = 0;
      m_since = 0;
    end
  endtask

  function automatic logic [10:0] model_out();
    return {4'(1 << m_colpos), 4'(m_code), m_valid, m_held, m_ovr};
  endfunction

  function automatic logic [10:0] dut_out();
    return {col, code, key_valid, key_held, overrun};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {col,code,v,h,o}=%b_%h_%b required %b_%h_%b",
               name, got[10:7], got[6:3], got[2:0], exp[10:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge
  task automatic tick(input logic [3:0] r, input bit a);
    row     = r;
    key_ack = a;
    @(posedge Clk);
    if (use_model) model_edge(r, a);
    @(negedge Clk);
  endtask

  initial begin
    vec_t       tbl[$];
    bit         saw;
    logic [3:0] rr;
    int         len;
    int         sel;

    // k = rising edges since reset release; col moves after samples at k = 7, 14, 21, ...
    tbl.push_back('{4'h0, 1'b0,   6, {4'b0001, 4'h0, 3'b000}});  // k6
    tbl.push_back('{4'h0, 1'b0,   1, {4'b0010, 4'h0, 3'b000}});  // k7 first rotation
    tbl.push_back('{4'h0, 1'b0,   7, {4'b0100, 4'h0, 3'b000}});  // k14
    tbl.push_back('{4'h2, 1'b0,   7, {4'b0100, 4'h0, 3'b000}});  // k21 detect, col frozen
    tbl.push_back('{4'h2, 1'b0,  13, {4'b0100, 4'h0, 3'b000}});  // k34 not yet
    tbl.push_back('{4'h2, 1'b0,   1, {4'b0100, 4'h6, 3'b110}});  // k35 accept code 6
    tbl.push_back('{4'h2, 1'b1,   1, {4'b0100, 4'h6, 3'b010}});  // k36 ack clears valid
    tbl.push_back('{4'h0, 1'b0,  19, {4'b0100, 4'h6, 3'b010}});  // k55 still held
    tbl.push_back('{4'h0, 1'b0,   1, {4'b1000, 4'h6, 3'b000}});  // k56 released
    tbl.push_back('{4'h1, 1'b0,   7, {4'b1000, 4'h6, 3'b000}});  // k63 bounce detected
    tbl.push_back('{4'h0, 1'b0,   7, {4'b0001, 4'h6, 3'b000}});  // k70 bounce rejected
    tbl.push_back('{4'h1, 1'b0,  21, {4'b0001, 4'h0, 3'b110}});  // k91 code 0, no ack
    tbl.push_back('{4'h0, 1'b0,  21, {4'b0010, 4'h0, 3'b100}});  // k112 released
    tbl.push_back('{4'h0, 1'b0,  19, {4'b1000, 4'h0, 3'b100}});  // k131
    tbl.push_back('{4'h8, 1'b0,   2, {4'b0001, 4'h0, 3'b100}});  // k133
    tbl.push_back('{4'h8, 1'b0,  20, {4'b0001, 4'h0, 3'b100}});  // k153
    tbl.push_back('{4'h8, 1'b0,   1, {4'b0001, 4'hC, 3'b111}});  // k154 overrun
    tbl.push_back('{4'h8, 1'b1,   1, {4'b0001, 4'hC, 3'b011}});  // k155 ack, overrun sticky
`ifdef KEYPAD_REPEAT_EN
    tbl.push_back('{4'h8, 1'b0, 500, {4'b0001, 4'hC, 3'b111}});  // repeat at k602
`else
    tbl.push_back('{4'h8, 1'b0, 500, {4'b0001, 4'hC, 3'b011}});  // single event only
`endif

    // Reset held with all rows asserted
    Reset_n = 1'b0;
    row     = 4'hF;
    key_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("reset_values", dut_out(), {4'b0001, 4'h0, 3'b000});
    row     = 4'h0;
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) tick(tbl[i].row, tbl[i].ack);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Reset during debounce after two matching samples
    Reset_n = 1'b0;
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    Reset_n = 1'b1;
    for (int c = 0; c < 10; c++) tick(4'h0, 1'b0);
    check("rst_seq_scan", dut_out(), {4'b0010, 4'h0, 3'b000});
    for (int c = 0; c < 11; c++) tick(4'h1, 1'b0);
    check("rst_seq_debounce", dut_out(), {4'b0010, 4'h0, 3'b000});
    tick(4'h1, 1'b0);
    #2 Reset_n = 1'b0;
    #1 check("rst_async", dut_out(), {4'b0001, 4'h0, 3'b000});
    row = 4'h0;
    @(negedge Clk);
    Reset_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(4'h0, 1'b0);
      saw = saw | key_valid | key_held;
    end
    check("rst_no_event", {10'h0, saw}, 11'h0);
    check("rst_after_scan", dut_out(), {4'b0001, 4'h0, 3'b000});

    // Random rows and acks against the model
    Reset_n = 1'b0;
    model_reset();
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    Reset_n   = 1'b1;
    use_model = 1'b1;
    for (int b = 0; b < 300; b++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2)       rr = 4'h0;
      else if (sel == 2) rr = 4'(1 << $urandom_range(0, 3));
      else               rr = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 50);
      for (int c = 0; c < len; c++) begin
        tick(rr, $urandom_range(0, 7) == 0);
        check($sformatf("model_b%0d_c%0d", b, c), dut_out(), model_out());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It sequences the one-hot column strobes and samples the row lines through a synchronizer. It debounces press and release, then hands a 4-bit key code to the display/consumer logic through a valid/ack handshake. It sits between the keypad pins and the key-code consumer, replacing free-running column rotation with a state-machine-owned scan.

## Interface
- SCAN_DIV, 7, clock cycles each column is driven before the row lines are sampled; legal range is ≥4.
- DEBOUNCE_SCANS, 3, consecutive matching samples needed to accept a press, and consecutive all-zero samples needed to accept a release; legal range is ≥1.
- REPEAT_SCANS, 64, sample periods between auto-repeat events; used only when KEYPAD_REPEAT_EN is defined.
- Clk  in  1  single clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- row  in  4  raw keypad row lines, active-high, asynchronous to Clk.
- key_ack  in  1  consumer accepts the pending code.
- col  out  4  one-hot column drive, active-high.
- code  out  4  key code = row_index*4 + col_index.
- key_valid  out  1  a code is pending; held until acknowledged.
- key_held  out  1  a debounced key is currently down.
- overrun  out  1  sticky flag: a new event arrived while key_valid was high; cleared only by reset.

## Operation
- Row input passes through a 2-flop synchronizer, giving row_s.
- A dwell counter counts 0..SCAN_DIV-1. A sample event occurs when the counter reaches SCAN_DIV-1; row_s is examined only then.
- Row decode: the lowest set bit of row_s wins. Ghosting resolves to the lowest row index.
- FSM states:
  - SCAN: at each sample with row_s==0, rotate col 0001→0010→0100→1000→0001. With row_s!=0, latch the candidate code, set match count to 1, freeze col, go to DEBOUNCE. If DEBOUNCE_SCANS==1, go directly to the accept action.
  - DEBOUNCE: at each sample, if the decoded row equals the candidate, increment the match count. When the count reaches DEBOUNCE_SCANS, accept. On mismatch (including zero), rotate col and return to SCAN.
  - Accept action: update code; set key_valid; set key_held; go to HELD. If key_valid was already high, set overrun and overwrite code.
  - HELD: col stays frozen. At each sample, row_s==0 increments the release count; any nonzero value clears it. When the release count reaches DEBOUNCE_SCANS, clear key_held, rotate col, go to SCAN.
- Handshake: key_valid clears on the cycle after key_ack is sampled high while key_valid is high. If key_ack and a new accept fall in the same cycle, the accept wins: key_valid stays 1, code takes the new value, and overrun is not set. key_ack while key_valid is low is ignored.

## Timing
- Reset values:
  - col=4'b0001, code=4'h0.
  - key_valid=0, key_held=0, overrun=0.
  - FSM=SCAN; dwell, match and release counters=0; synchronizer flops=0.
- Reset asserted mid-operation returns to the reset state immediately (asynchronously); no event is emitted.
- col changes only on the cycle after a sample event, so every column is driven for exactly SCAN_DIV cycles.
- Press latency: key_valid rises 1 cycle after the DEBOUNCE_SCANS-th matching sample. Measured from the first detecting sample, this is (DEBOUNCE_SCANS-1)*SCAN_DIV+1 cycles.
- The row-to-sample path adds 2 cycles of synchronizer delay. A row change reaching row_s less than 2 cycles before a sample is seen at the next sample.
- Release latency: key_held falls 1 cycle after the DEBOUNCE_SCANS-th zero sample.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter counts sample periods since accept.
  - Every REPEAT_SCANS samples, the accept action is repeated with the same code, including the overrun rule.
  - Any nonzero release count resets the repeat counter.
- KEYPAD_REPEAT_EN undefined: exactly one event per press, no repeat counter is synthesized, and REPEAT_SCANS is ignored.

## Structure
- Shared package keypad_pkg:
  - FSM state typedef (SCAN, DEBOUNCE, HELD).
  - Column one-hot constants.
  - Code-encode function (row index, col index → 4-bit code).
- One sub-module, keypad_row_sync: 4-bit 2-flop synchronizer with async active-low reset.
- The dwell counter and FSM live in keypad_scan_ctrl.

## Test plan
- Reset: hold Reset_n=0 with row=4'hF → col=0001, code=0, key_valid=0, key_held=0, overrun=0. After release with row=0, col rotates every 7 cycles.
- Single press: apply row=4'b0010 while col=0100 and hold it; defaults → code=4'h6 and key_valid=1 exactly 15 cycles after the detecting sample. Pulse key_ack → key_valid=0 next cycle.
- Bounce reject: row=4'b0001 for one sample only, then 0 → no key_valid; col resumes rotation from the next column.
- Release and overrun: press code 4'h0 with no ack, release for 3 samples, then press row=4'b1000 at col=0001 → key_held falls, then code=4'hC and overrun=1.
- Reset mid-DEBOUNCE: drop Reset_n after 2 matching samples → all outputs at reset values; no key_valid after Reset_n returns high with row=0.
- Repeat (KEYPAD_REPEAT_EN): hold row=4'b0100 at col=0010 and ack each event → code=4'h9 re-raised every 64 samples (448 cycles). With the macro undefined → only one event.
